ddr3_init_seq: RTL

Power-up initialization sequencer for the DDR3 memory controller. It sits directly upstream of the command/address pins and runs the JEDEC reset/CKE/MRS/ZQCL sequence that programs the mode registers MR2, MR3, MR1 and MR0. It signals init_done so the main controller can leave INIT for IDLE. Packed 16-bit mode-register words arrive already assembled from the controller's MR0–MR3 fields.

---
 rtl/ddr3_init_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE bring-up, MR2/MR3/MR1/MR0 programming, ZQCL.
// All pin outputs are registered from the current state, so they lag the state by one cycle.
module ddr3_init_seq #(
    parameter int T_RESET  = 200,
    parameter int T_CKE    = 500,
    parameter int T_XPR    = 5,
    parameter int T_MRD    = 4,
    parameter int T_MOD    = 12,
    parameter int T_ZQINIT = 512,
    parameter int CNT_W    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] mr0,
    input  logic [15:0] mr1,
    input  logic [15:0] mr2,
    input  logic [15:0] mr3,
    output logic        ddr_rst_n,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [2:0]  ba,
    output logic [15:0] addr,
    output logic        busy,
    output logic        init_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_CKE, S_XPR, S_MRS, S_MRD, S_ZQ, S_ZQW, S_DONE
    } state_t;

    localparam logic [3:0] CMD_DES  = 4'b1111;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    // Single-cycle issue states already account for one cycle of spacing,
    // hence the -2 loads for the waits that follow an issue.
    localparam logic [CNT_W-1:0] LD_RST = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] LD_CKE = CNT_W'(T_CKE - 1);
    localparam logic [CNT_W-1:0] LD_XPR = CNT_W'(T_XPR - 1);
    localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 2);
    localparam logic [CNT_W-1:0] LD_MOD = CNT_W'(T_MOD - 2);
    localparam logic [CNT_W-1:0] LD_ZQ  = CNT_W'(T_ZQINIT - 2);

    if (T_RESET < 1 || T_CKE < 1 || T_XPR < 1 || T_MRD < 1 || T_MOD < 1 || T_ZQINIT < 1)
    begin : g_param_min
        $error("ddr3_init_seq: all T_* parameters must be >= 1");
    end
    if (T_RESET > 2**CNT_W || T_CKE > 2**CNT_W || T_XPR > 2**CNT_W ||
        T_MRD > 2**CNT_W || T_MOD > 2**CNT_W || T_ZQINIT > 2**CNT_W)
    begin : g_param_width
        $error("ddr3_init_seq: CNT_W too narrow for T_* parameters");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       seq, seq_nx;
    logic             cnt_zero;

    logic        rst_n_nx, cke_nx, busy_nx, done_nx;
    logic [3:0]  cmd_nx;
    logic [2:0]  ba_nx;
    logic [15:0] addr_nx;
    logic [2:0]  mr_ba;
    logic [15:0] mr_sel;

    assign cnt_zero = (cnt == '0);

    // Programming order MR2, MR3, MR1, MR0 keyed by the sequence pointer.
    always_comb begin
        mr_ba  = 3'd0;
        mr_sel = mr0;
        case (seq)
            2'd0: begin mr_ba = 3'd2; mr_sel = mr2; end
            2'd1: begin mr_ba = 3'd3; mr_sel = mr3; end
            2'd2: begin mr_ba = 3'd1; mr_sel = mr1; end
            default: begin mr_ba = 3'd0; mr_sel = mr0; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            seq       <= 2'd0;
            ddr_rst_n <= 1'b0;
            cke       <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
            ba        <= 3'd0;
            addr      <= 16'd0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            seq       <= seq_nx;
            ddr_rst_n <= rst_n_nx;
            cke       <= cke_nx;
            {cs_n, ras_n, cas_n, we_n} <= cmd_nx;
            ba        <= ba_nx;
            addr      <= addr_nx;
            busy      <= busy_nx;
            init_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_zero ? '0 : cnt - CNT_W'(1);
        seq_nx   = seq;
        rst_n_nx = 1'b0;
        cke_nx   = 1'b0;
        cmd_nx   = CMD_DES;
        ba_nx    = 3'd0;
        addr_nx  = 16'd0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RST;
                    cnt_nx   = LD_RST;
                    seq_nx   = 2'd0;
                end
            end
            S_RST: begin
                busy_nx = 1'b1;
                if (cnt_zero) begin
                    state_nx = S_CKE;
                    cnt_nx   = LD_CKE;
                end
            end
            S_CKE: begin
                rst_n_nx = 1'b1;
                busy_nx  = 1'b1;
                if (cnt_zero) begin
                    state_nx = S_XPR;
                    cnt_nx   = LD_XPR;
                end
            end
            S_XPR: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_NOP;
                busy_nx  = 1'b1;
                if (cnt_zero) state_nx = S_MRS;
            end
            S_MRS: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_MRS;
                ba_nx    = mr_ba;
                addr_nx  = mr_sel;
                busy_nx  = 1'b1;
                seq_nx   = seq + 2'd1;
                if (seq == 2'd3) begin
                    if (T_MOD > 1) begin
                        state_nx = S_MRD;
                        cnt_nx   = LD_MOD;
                    end else begin
                        state_nx = S_ZQ;
                    end
                end else if (T_MRD > 1) begin
                    state_nx = S_MRD;
                    cnt_nx   = LD_MRD;
                end
            end
            S_MRD: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_NOP;
                busy_nx  = 1'b1;
                // Pointer has wrapped to 0 only after MR0 went out.
                if (cnt_zero) state_nx = (seq == 2'd0) ? S_ZQ : S_MRS;
            end
            S_ZQ: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_ZQCL;
                addr_nx  = 16'h0400;
                busy_nx  = 1'b1;
                if (T_ZQINIT > 1) begin
                    state_nx = S_ZQW;
                    cnt_nx   = LD_ZQ;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_ZQW: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_NOP;
                busy_nx  = 1'b1;
                if (cnt_zero) state_nx = S_DONE;
            end
            S_DONE: begin
                rst_n_nx = 1'b1;
                cke_nx   = 1'b1;
                cmd_nx   = CMD_NOP;
                done_nx  = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                seq_nx   = 2'd0;
            end
        endcase
    end

endmodule
